// File: rtl/flow_control_loop_pipe_seq_init_pkg.sv
// Shared constants for the sequential loop-control shim.
// Imported by the interface and the top.
package flow_control_loop_pipe_seq_init_pkg;
    localparam logic CONTINUE_TIED = 1'b1;
endpackage

// File: rtl/flow_control_loop_pipe_seq_init_if.sv
// Handshake bundle between parent FSM, loop body and the shim.
// slave = shim side, master = parent/loop side.
interface flow_control_loop_pipe_seq_init_if;
    import flow_control_loop_pipe_seq_init_pkg::*;

    logic ap_start;
    logic ap_ready;
    logic ap_done;
    logic ap_start_int;
    logic ap_continue_int;
    logic ap_loop_init;
    logic ap_ready_int;
    logic ap_loop_exit_ready;
    logic ap_loop_exit_done;
    logic ap_done_int;

    modport slave (
        input  ap_start,
        input  ap_ready_int,
        input  ap_loop_exit_ready,
        input  ap_loop_exit_done,
        input  ap_done_int,
        output ap_ready,
        output ap_done,
        output ap_start_int,
        output ap_continue_int,
        output ap_loop_init
    );

    modport master (
        output ap_start,
        output ap_ready_int,
        output ap_loop_exit_ready,
        output ap_loop_exit_done,
        output ap_done_int,
        input  ap_ready,
        input  ap_done,
        input  ap_start_int,
        input  ap_continue_int,
        input  ap_loop_init
    );
endinterface

// File: rtl/flow_control_loop_pipe_seq_init.sv
// ap_ctrl_hs shim for a pipelined loop without external continue:
// forwards start, reports ready/done, and drives the loop_init pulse.
module flow_control_loop_pipe_seq_init
    import flow_control_loop_pipe_seq_init_pkg::*;
(
    input logic ap_clk,
    input logic ap_rst_n,
    flow_control_loop_pipe_seq_init_if.slave bus
);

    logic loop_init_r;
    logic done_cache;
    logic unused_done_int;

    assign bus.ap_start_int    = bus.ap_start;
    assign bus.ap_continue_int = CONTINUE_TIED;
    assign bus.ap_ready        = bus.ap_loop_exit_ready;
    assign bus.ap_loop_init    = loop_init_r & bus.ap_start;

    // done_int mirrors exit_done at the parent; nothing consumes it here
    assign unused_done_int = bus.ap_done_int;

    // Exit re-arms before an accepted iteration can clear it
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            loop_init_r <= 1'b1;
        end else if (bus.ap_loop_exit_done) begin
            loop_init_r <= 1'b1;
        end else if (bus.ap_ready_int) begin
            loop_init_r <= 1'b0;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            done_cache <= 1'b0;
        end else if (bus.ap_loop_exit_done) begin
            done_cache <= 1'b1;
        end else if (bus.ap_start_int) begin
            done_cache <= 1'b0;
        end
    end

    // Live exit gives zero-latency done; idle cycles replay the cache
    always_comb begin
        bus.ap_done = bus.ap_loop_exit_done;
        if (!bus.ap_loop_exit_done && !bus.ap_start_int) begin
            bus.ap_done = done_cache;
        end
    end

endmodule

// File: tb/tb_flow_control_loop_pipe_seq_init.sv
// Directed plus random bench for the sequential loop-control shim.
// Outputs are checked mid-cycle against a run-level reference model.
module tb_flow_control_loop_pipe_seq_init;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    // Reference model: "first iteration still pending" and
    // "a run finished and no new start has been seen yet"
    bit first_pending;
    bit finished_unseen;

    flow_control_loop_pipe_seq_init_if bus ();

    flow_control_loop_pipe_seq_init dut (
        .ap_clk  (clk),
        .ap_rst_n(rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit s, input bit ri, input bit er, input bit ed);
        bus.ap_start           = s;
        bus.ap_ready_int       = ri;
        bus.ap_loop_exit_ready = er;
        bus.ap_loop_exit_done  = ed;
        bus.ap_done_int        = ed;
        #1;
    endtask

    task automatic check_model(input string tag);
        bit exp_done;
        if (bus.ap_loop_exit_done) exp_done = 1'b1;
        else if (bus.ap_start)     exp_done = 1'b0;
        else                       exp_done = finished_unseen;
        chk({tag, ".ready"},    bus.ap_ready,        bus.ap_loop_exit_ready);
        chk({tag, ".start_int"}, bus.ap_start_int,   bus.ap_start);
        chk({tag, ".cont"},     bus.ap_continue_int, 1'b1);
        chk({tag, ".init"},     bus.ap_loop_init,    first_pending && bus.ap_start);
        chk({tag, ".done"},     bus.ap_done,         exp_done);
    endtask

    // Clock edge: advance the model with the inputs held across it
    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            if (bus.ap_loop_exit_done) begin
                first_pending   = 1'b1;
                finished_unseen = 1'b1;
            end else begin
                if (bus.ap_ready_int) first_pending = 1'b0;
                if (bus.ap_start)     finished_unseen = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic model_reset();
        first_pending   = 1'b1;
        finished_unseen = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        model_reset();
        drive(0, 0, 0, 0);
        @(negedge clk);

        // Reset state with all inputs low
        check_model("rst");
        chk("rst.done_c", bus.ap_done, 1'b0);
        chk("rst.init_c", bus.ap_loop_init, 1'b0);
        chk("rst.ready_c", bus.ap_ready, 1'b0);
        chk("rst.cont_c", bus.ap_continue_int, 1'b1);
        tick();
        rst_n = 1'b1;
        drive(0, 0, 0, 0);
        check_model("idle");
        tick();

        // 4-iteration run, exit in cycle 3
        drive(1, 1, 0, 0);
        check_model("c0");
        chk("c0.init_c", bus.ap_loop_init, 1'b1);
        tick();
        drive(1, 1, 0, 0);
        check_model("c1");
        chk("c1.init_c", bus.ap_loop_init, 1'b0);
        tick();
        drive(1, 1, 0, 0);
        check_model("c2");
        tick();
        drive(1, 1, 1, 1);
        check_model("c3");
        chk("c3.ready_c", bus.ap_ready, 1'b1);
        chk("c3.done_c", bus.ap_done, 1'b1);
        tick();
        drive(0, 0, 0, 0);
        check_model("c4");
        chk("c4.done_c", bus.ap_done, 1'b1);
        chk("c4.init_c", bus.ap_loop_init, 1'b0);
        tick();
        drive(0, 0, 0, 0);
        check_model("c5");
        chk("c5.done_c", bus.ap_done, 1'b1);
        tick();

        // Restart: done suppressed, init re-armed, cache cleared
        drive(1, 1, 0, 0);
        check_model("c6");
        chk("c6.done_c", bus.ap_done, 1'b0);
        chk("c6.init_c", bus.ap_loop_init, 1'b1);
        tick();
        drive(0, 0, 0, 0);
        check_model("c7");
        chk("c7.done_c", bus.ap_done, 1'b0);
        tick();

        // Exit and accept in the same cycle: exit wins
        drive(1, 1, 1, 1);
        check_model("both");
        tick();
        drive(1, 0, 0, 0);
        check_model("both_n");
        chk("both_n.init_c", bus.ap_loop_init, 1'b1);
        tick();

        // Build cached done, then reset asynchronously mid-cycle
        drive(1, 1, 1, 1);
        check_model("pre_rst");
        tick();
        drive(0, 0, 0, 0);
        chk("cache_c", bus.ap_done, 1'b1);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst.done_c", bus.ap_done, 1'b0);
        check_model("arst");
        tick();
        rst_n = 1'b1;
        drive(1, 0, 0, 0);
        check_model("post_rst");
        chk("post_rst.init_c", bus.ap_loop_init, 1'b1);
        tick();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            bit s, ri, ex, er;
            s  = ($urandom_range(0, 3) != 0);
            ri = s && ($urandom_range(0, 1) != 0);
            ex = ($urandom_range(0, 7) == 0);
            er = ex && ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 63) == 0) begin
                rst_n = 1'b0;
                model_reset();
            end else begin
                rst_n = 1'b1;
            end
            drive(s, ri, er, ex);
            check_model("rnd");
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
